// File: rtl/channel_rx_pkg.sv
// Shared types and constants for the channel receiver: framing state enum,
// default sync byte and the integrator width helper.
package channel_rx_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } rx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;
    localparam int         SAMPLE_WIDTH      = 9;

    // Sum of N signed samples needs log2(N) extra bits to never wrap.
    function automatic int acc_width(input int samples_per_bit);
        return SAMPLE_WIDTH + $clog2(samples_per_bit);
    endfunction

endpackage

// File: rtl/rx_bit_slicer.sv
// Integrate-and-dump bit slicer: samples the channel once per update period,
// sums a fixed number of samples and decides each bit by the sign of the sum.
module rx_bit_slicer
    import channel_rx_pkg::*;
#(
    parameter int SAMPLE_PERIOD   = 4,
    parameter int SAMPLE_PHASE    = 0,
    parameter int SAMPLES_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic [8:0] channel_in,
    output logic       dec_bit,
    output logic       dec_valid,
    output logic       bit_out,
    output logic       bit_valid
);

    localparam int PHASE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CNT_W   = $clog2(SAMPLES_PER_BIT);
    localparam int ACC_W   = acc_width(SAMPLES_PER_BIT);

    logic [PHASE_W-1:0]       phase;
    logic [CNT_W-1:0]         sample_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     strobe;
    logic                     last_sample;

    assign sample_ext  = {{(ACC_W-SAMPLE_WIDTH){channel_in[SAMPLE_WIDTH-1]}}, channel_in};
    assign strobe      = (phase == PHASE_W'(SAMPLE_PHASE)) && rx_en;
    assign last_sample = (sample_cnt == CNT_W'(SAMPLES_PER_BIT - 1));
    assign sum         = acc + sample_ext;

    // Decision is made on the sum including the current sample; zero counts as 0.
    assign dec_valid = strobe && last_sample;
    assign dec_bit   = !sum[ACC_W-1] && (sum != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
        end else begin
            phase     <= (phase == PHASE_W'(SAMPLE_PERIOD - 1)) ? '0 : phase + 1'b1;
            bit_valid <= dec_valid;
            if (dec_valid) begin
                bit_out <= dec_bit;
            end
            if (!rx_en) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (strobe) begin
                if (last_sample) begin
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/channel_rx.sv
// Channel receiver top: bit slicer plus a HUNT/DATA framing FSM that finds the
// sync byte and then delivers a fixed number of data bytes.
module channel_rx
    import channel_rx_pkg::*;
#(
    parameter int         SAMPLE_PERIOD   = 4,
    parameter int         SAMPLE_PHASE    = 0,
    parameter int         SAMPLES_PER_BIT = 4,
    parameter logic [7:0] SYNC_WORD       = DEFAULT_SYNC_WORD,
    parameter int         FRAME_BYTES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic [8:0] channel_in,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       in_frame,
    output logic       frame_abort
);

    localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    rx_state_t         state, state_n;
    logic [7:0]        shreg, shreg_n, shifted;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0] byte_cnt, byte_cnt_n;
    logic [7:0]        rx_data_n;
    logic              rx_valid_n;
    logic              frame_abort_n;
    logic              dec_bit;
    logic              dec_valid;

    rx_bit_slicer #(
        .SAMPLE_PERIOD   (SAMPLE_PERIOD),
        .SAMPLE_PHASE    (SAMPLE_PHASE),
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
    ) u_slicer (
        .clk        (clk),
        .reset      (reset),
        .rx_en      (rx_en),
        .channel_in (channel_in),
        .dec_bit    (dec_bit),
        .dec_valid  (dec_valid),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid)
    );

    assign shifted  = {shreg[6:0], dec_bit};
    assign in_frame = (state == DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            shreg       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            byte_cnt    <= byte_cnt_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            frame_abort <= frame_abort_n;
        end
    end

    // The FSM reacts to the slicer's combinational decision so that byte and
    // state updates land on the same edge that registers bit_valid.
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        bit_cnt_n     = bit_cnt;
        byte_cnt_n    = byte_cnt;
        rx_data_n     = rx_data;
        rx_valid_n    = 1'b0;
        frame_abort_n = 1'b0;

        if (!rx_en) begin
            state_n       = HUNT;
            shreg_n       = '0;
            bit_cnt_n     = '0;
            byte_cnt_n    = '0;
            frame_abort_n = (state == DATA);
        end else if (dec_valid) begin
            unique case (state)
                HUNT: begin
                    if (shifted == SYNC_WORD) begin
                        state_n    = DATA;
                        shreg_n    = '0;
                        bit_cnt_n  = '0;
                        byte_cnt_n = '0;
                    end else begin
                        shreg_n = shifted;
                    end
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
                        rx_data_n  = shifted;
                        rx_valid_n = 1'b1;
                        shreg_n    = '0;
                        bit_cnt_n  = '0;
                        if (byte_cnt == BYTE_W'(FRAME_BYTES - 1)) begin
                            state_n    = HUNT;
                            byte_cnt_n = '0;
                        end else begin
                            byte_cnt_n = byte_cnt + 1'b1;
                        end
                    end else begin
                        shreg_n   = shifted;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_rx.sv
// Directed bench for channel_rx: table of integrate-and-dump vectors plus
// hand-written frame, noise, idle, abort and mid-frame reset sequences.
module tb_channel_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic [8:0] channel_in;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       in_frame;
    logic       frame_abort;

    int total = 0;
    int bad   = 0;

    int cyc;
    int bv_cnt, bv_ones, first_bv, last_bit;
    int abort_cnt, abort_cyc;
    int if_cycles, if_rise, if_fall;
    logic prev_if;
    logic [7:0] rx_d[$];
    int         rx_c[$];

    typedef struct {
        string           name;
        logic [3:0][8:0] s;
        logic            exp_bit;
    } vec_t;

    vec_t vecs[10];

    channel_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx_en       (rx_en),
        .channel_in  (channel_in),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .in_frame    (in_frame),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, int a, int b, int c, int d, logic e);
        vec_t v;
        v.name    = n;
        v.s[0]    = 9'(a);
        v.s[1]    = 9'(b);
        v.s[2]    = 9'(c);
        v.s[3]    = 9'(d);
        v.exp_bit = e;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_monitors();
        bv_cnt    = 0;
        bv_ones   = 0;
        first_bv  = -1;
        last_bit  = -1;
        abort_cnt = 0;
        abort_cyc = -1;
        if_cycles = 0;
        if_rise   = -1;
        if_fall   = -1;
        rx_d.delete();
        rx_c.delete();
    endtask

    // Drive one cycle of input, then observe outputs 1 time unit after the edge.
    task automatic step(input logic [8:0] v);
        channel_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (bit_valid) begin
            bv_cnt++;
            bv_ones += int'(bit_out);
            last_bit = int'(bit_out);
            if (first_bv < 0) first_bv = cyc;
        end
        if (rx_valid) begin
            rx_d.push_back(rx_data);
            rx_c.push_back(cyc);
        end
        if (frame_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (in_frame) begin
            if_cycles++;
            if (!prev_if) if_rise = cyc;
        end else if (prev_if) begin
            if_fall = cyc;
        end
        prev_if = in_frame;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_en = 1'b1;
        step(9'h0FF);
        step(9'h0FF);
        reset   = 1'b0;
        cyc     = 0;
        prev_if = 1'b0;
        clear_monitors();
    endtask

    task automatic apply_stimulus(input logic [3:0][8:0] s);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                step(s[j]);
    endtask

    task automatic send_bit(input logic b, input logic noisy);
        int v;
        for (int i = 0; i < 16; i++) begin
            v = b ? 64 : -64;
            if (noisy) v += (((i / 4) % 2) == 0) ? 16 : -16;
            step(9'(v));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic noisy);
        for (int k = 7; k >= 0; k--) send_bit(b[k], noisy);
    endtask

    task automatic send_frame(input logic noisy);
        send_byte(8'hA5, noisy);
        send_byte(8'h3C, noisy);
        send_byte(8'hC3, noisy);
    endtask

    task automatic check_frame(input string tag, input logic check_timing);
        check_output({tag, " rx count"}, rx_d.size(), 2);
        if (rx_d.size() == 2) begin
            check_output({tag, " byte0"}, int'(rx_d[0]), 8'h3C);
            check_output({tag, " byte1"}, int'(rx_d[1]), 8'hC3);
            if (check_timing) begin
                check_output({tag, " byte0 cycle"}, rx_c[0], 253);
                check_output({tag, " byte1 cycle"}, rx_c[1], 381);
            end
        end
        if (check_timing) begin
            check_output({tag, " in_frame rise"}, if_rise, 125);
            check_output({tag, " in_frame fall"}, if_fall, 381);
            check_output({tag, " in_frame cycles"}, if_cycles, 256);
        end
        check_output({tag, " back to hunt"}, int'(in_frame), 0);
    endtask

    initial begin
        vecs[0] = mk("tie +5-5+3-3",  5,  -5,   3,  -3,  1'b0);
        vecs[1] = mk("min -256x4",  -256, -256, -256, -256, 1'b0);
        vecs[2] = mk("max +255x4",   255,  255,  255,  255, 1'b1);
        vecs[3] = mk("clean one",     64,   64,   64,   64, 1'b1);
        vecs[4] = mk("clean zero",   -64,  -64,  -64,  -64, 1'b0);
        vecs[5] = mk("single +1",      1,    0,    0,    0, 1'b1);
        vecs[6] = mk("all zero",       0,    0,    0,    0, 1'b0);
        vecs[7] = mk("tie -1+1",      -1,    0,    0,    1, 1'b0);
        vecs[8] = mk("sum +1",       100,  -50,  -30,  -19, 1'b1);
        vecs[9] = mk("sum -1",      -100,   50,   30,   19, 1'b0);

        reset      = 1'b1;
        rx_en      = 1'b1;
        channel_in = 9'h0FF;
        cyc        = 0;
        prev_if    = 1'b0;
        clear_monitors();

        // Reset state with live input present.
        step(9'h0FF);
        step(9'h0FF);
        check_output("reset outputs",
                     int'({bit_out, bit_valid, rx_data, rx_valid, in_frame, frame_abort}), 0);

        // First bit latency after reset.
        do_reset();
        send_bit(1'b1, 1'b0);
        check_output("first bit cycle", first_bv, 13);
        check_output("first bit value", last_bit, 1);

        // Table of integrate-and-dump decisions.
        for (int n = 0; n < 10; n++) begin
            bv_cnt   = 0;
            last_bit = -1;
            apply_stimulus(vecs[n].s);
            check_output({vecs[n].name, " valid"}, bv_cnt, 1);
            check_output(vecs[n].name, last_bit, int'(vecs[n].exp_bit));
        end
        check_output("table no sync", if_cycles, 0);

        // Clean and noisy frames: same bytes and same timing.
        do_reset();
        send_frame(1'b0);
        check_frame("clean", 1'b1);

        do_reset();
        send_frame(1'b1);
        check_frame("noisy", 1'b1);

        // Constant zero input never syncs.
        do_reset();
        for (int i = 0; i < 200; i++) step(9'h000);
        check_output("idle bit count", bv_cnt, 12);
        check_output("idle ones", bv_ones, 0);
        check_output("idle rx count", rx_d.size(), 0);
        check_output("idle in_frame", if_cycles, 0);

        // Abort after three data bits, then resend.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check_output("abort pre in_frame", int'(in_frame), 1);
        rx_en = 1'b0;
        for (int i = 0; i < 20; i++) step(9'h040);
        check_output("abort count", abort_cnt, 1);
        check_output("abort cycle", abort_cyc, 177);
        check_output("abort no rx", rx_d.size(), 0);
        check_output("abort hunt", int'(in_frame), 0);
        rx_en = 1'b1;
        rx_d.delete();
        rx_c.delete();
        send_frame(1'b0);
        check_frame("resend", 1'b0);
        check_output("resend abort count", abort_cnt, 1);

        // Reset in the middle of a frame.
        do_reset();
        send_frame(1'b0);
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
        check_output("midreset pre in_frame", int'(in_frame), 1);
        check_output("midreset pre rx_data", int'(rx_data), 8'hC3);
        reset = 1'b1;
        step(9'h040);
        check_output("midreset outputs",
                     int'({bit_out, bit_valid, rx_data, rx_valid, in_frame, frame_abort}), 0);
        check_output("midreset no abort", abort_cnt, 0);
        do_reset();
        send_frame(1'b0);
        check_frame("after reset", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
